uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver that recovers 8-bit bytes from the RX line. The frame format is 1 start bit (low), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), and 1 stop bit (high). It is the receive end of the link that the team's UART transmitter drives. It sits between the FPGA RX pin and the byte-consumer logic, and reports each byte with a one-cycle valid strobe plus parity and framing error flags.

## Interface
- CLKS_PER_BIT, 10, clock cycles per bit period; legal range 4..65535.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces every register to its reset value immediately.
- i_rx  input  1  serial RX line; idles high.
- o_data_byte  output  8  last received byte; holds its value until the next completed frame.
- o_data_valid  output  1  one-cycle pulse when a frame completes with its stop bit high.
- o_parity_err  output  1  one-cycle pulse, coincident with o_data_valid, when the received parity bit differs from ^data.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low; o_data_valid stays 0 for that frame.
- o_active  output  1  high while a frame is being received (START through STOP).

## Operation
- rx_s is the sampled line: i_rx through the synchronizer (see Configuration), or i_rx directly.
- H = (CLKS_PER_BIT-1)/2, integer division. A 16-bit bit-period counter and a 3-bit bit index are used.
- IDLE: counter=0, index=0, o_active=0. On rx_s==0 go to START with o_active<=1.
- START: counter increments each cycle. When counter==H, rx_s is checked:
  - low: counter<=0, go to DATA.
  - high: treat as a glitch, o_active<=0, return to IDLE with no flags.
- DATA: when counter==CLKS_PER_BIT-1:
  - shift buffer[index]<=rx_s, counter<=0.
  - index<7: index++. index==7: go to PARITY.
  - Otherwise counter++.
- PARITY: at counter==CLKS_PER_BIT-1, latch the parity bit, counter<=0, go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s, o_active<=0, then:
  - rx_s=1: o_data_byte<=buffer, o_data_valid<=1, o_parity_err<=(parity bit != ^buffer), go to IDLE.
  - rx_s=0: o_frame_err<=1, o_data_byte unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This blocks a false start on a held-low line (break).
- o_data_valid, o_parity_err and o_frame_err default to 0 every cycle.
- Undefined state encodings go to IDLE.
- Reset asserted mid-frame aborts the frame. No flags are produced, and reception restarts on the first low after release.

## Timing
- Reset values: o_data_byte=0x00, o_data_valid=0, o_parity_err=0, o_frame_err=0, o_active=0, state=IDLE.
- Let E0 be the edge where IDLE sees rx_s==0. The start check occurs at E0+H+1.
- Data bit n (0..7) is sampled CLKS_PER_BIT*(n+1) cycles after the start check. Parity is sampled 9*CLKS_PER_BIT after it, and stop 10*CLKS_PER_BIT after it.
- Flags and o_data_byte update on the stop-sample edge and are visible for exactly one cycle after it.
- Back-to-back frames: the stop is sampled mid-bit, so IDLE is re-entered with about half a bit period of margin. A start bit immediately following the stop bit is accepted with no lost frame.
- No backpressure: the consumer must take o_data_byte on o_data_valid. The register is overwritten only on the next valid frame.

## Configuration
- UART_RX_SYNC_EN defined: i_rx passes through a 2-flop synchronizer (both flops reset to 1) before it is used as rx_s. All sample points shift 2 cycles later relative to i_rx.
- UART_RX_SYNC_EN undefined: rx_s = i_rx directly. Use only when i_rx is already synchronous to clk. Latency is 2 cycles lower.

## Test plan
- CLKS_PER_BIT=10: send frame 0xA5 with parity 0 and stop 1 -> o_data_byte=0xA5, a single o_data_valid pulse, o_parity_err=0, o_frame_err=0; o_active high for about 10.5 bit periods.
- Send 0x01 with parity bit 0 (expected 1) -> o_data_byte=0x01, o_data_valid=1 and o_parity_err=1 on the same cycle.
- Pulse i_rx low for 3 cycles, then high -> no flags, o_active returns to 0, state IDLE; a following valid 0x3C frame is received correctly.
- Send 0x55 with stop bit 0, then hold i_rx low for 30 cycles before releasing it -> one o_frame_err pulse, no o_data_valid, no new frame started until i_rx returns high; o_data_byte keeps its previous value.
- Send 0x00, 0xFF, 0x80 back to back with no idle gap -> three o_data_valid pulses in order, all with o_parity_err=0.
- Drive reset low during data bit 4, release it, then send 0x7E -> all outputs 0 during reset; only 0x7E is reported afterwards.

Source files
------------

// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Brief    : 8E1 UART receiver (start, 8 data LSB first, even parity, stop).
//            Optional 2-flop input synchronizer: define UART_RX_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_data_byte,
    output logic       o_data_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_active
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic        rx_s;
    logic [2:0]  state;
    logic [15:0] counter;
    logic [2:0]  bit_index;
    logic [7:0]  buffer;
    logic        parity_bit;

`ifdef UART_RX_SYNC_EN
    logic sync_meta;
    logic sync_out;

    // Both flops reset high so the idle line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= i_rx;
            sync_out  <= sync_meta;
        end
    end

    assign rx_s = sync_out;
`else
    assign rx_s = i_rx;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            counter      <= 16'd0;
            bit_index    <= 3'd0;
            buffer       <= 8'h00;
            parity_bit   <= 1'b0;
            o_data_byte  <= 8'h00;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_active     <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    counter   <= 16'd0;
                    bit_index <= 3'd0;
                    o_active  <= 1'b0;
                    if (!rx_s) begin
                        state    <= S_START;
                        o_active <= 1'b1;
                    end
                end

                S_START: begin
                    if (counter == HALF_CNT) begin
                        counter <= 16'd0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            // Start bit did not survive to mid-bit: a glitch.
                            state    <= S_IDLE;
                            o_active <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                S_DATA: begin
                    if (counter == LAST_CNT) begin
                        counter           <= 16'd0;
                        buffer[bit_index] <= rx_s;
                        if (bit_index == 3'd7) begin
                            state <= S_PARITY;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                S_PARITY: begin
                    if (counter == LAST_CNT) begin
                        counter    <= 16'd0;
                        parity_bit <= rx_s;
                        state      <= S_STOP;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                S_STOP: begin
                    if (counter == LAST_CNT) begin
                        counter  <= 16'd0;
                        o_active <= 1'b0;
                        if (rx_s) begin
                            o_data_byte  <= buffer;
                            o_data_valid <= 1'b1;
                            o_parity_err <= (parity_bit != ^buffer);
                            state        <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                // A held-low (break) line must return high before a new start.
                S_WAIT_HIGH: begin
                    counter   <= 16'd0;
                    bit_index <= 3'd0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed self-checking bench for uart_receiver (CLKS_PER_BIT=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

    localparam int CPB = 10;

    logic       clk;
    logic       reset;
    logic       i_rx;
    logic [7:0] o_data_byte;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_active;

    int total = 0;
    int bad   = 0;

    int valid_cnt  = 0;
    int perr_cnt   = 0;
    int ferr_cnt   = 0;
    int stray_perr = 0;
    int active_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_perr = 1'b0;
    logic [7:0] rx_log [$];
    logic       perr_log [$];

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (i_rx),
        .o_data_byte  (o_data_byte),
        .o_data_valid (o_data_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_active     (o_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event capture on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (o_data_valid) begin
            valid_cnt++;
            last_byte = o_data_byte;
            last_perr = o_parity_err;
            rx_log.push_back(o_data_byte);
            perr_log.push_back(o_parity_err);
        end
        if (o_parity_err) perr_cnt++;
        if (o_parity_err && !o_data_valid) stray_perr++;
        if (o_frame_err) ferr_cnt++;
        if (o_active) active_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of {stop, parity, data[7:0], start=0}, LSB first.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_rx = bits[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stp);
        send_bits({stp, par, data, 1'b0}, 11);
    endtask

    initial begin
        int v0;
        int f0;

        reset = 1'b0;
        i_rx  = 1'b1;
        #1;
        chk("reset_byte",   32'(o_data_byte),  32'h00);
        chk("reset_valid",  32'(o_data_valid), 32'h0);
        chk("reset_active", 32'(o_active),     32'h0);
        chk("reset_flags",  32'({o_parity_err, o_frame_err}), 32'h0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(5);

        // 0xA5: four ones, even parity 0.
        active_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cycles(20);
        chk("a5_valid_cnt", 32'(valid_cnt),  32'd1);
        chk("a5_byte",      32'(last_byte),  32'hA5);
        chk("a5_perr",      32'(perr_cnt),   32'd0);
        chk("a5_ferr",      32'(ferr_cnt),   32'd0);
        chk("a5_active_len", 32'(active_cnt), 32'd105);
        chk("a5_idle_active", 32'(o_active), 32'h0);

        // 0x01 with parity 0 where 1 is expected.
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cycles(20);
        chk("p01_valid_cnt", 32'(valid_cnt),  32'd2);
        chk("p01_byte",      32'(last_byte),  32'h01);
        chk("p01_perr_with_valid", 32'(last_perr), 32'h1);
        chk("p01_perr_cnt",  32'(perr_cnt),   32'd1);

        // 3-cycle glitch: start check at mid-bit sees the line high again.
        active_cnt = 0;
        i_rx = 1'b0;
        wait_cycles(3);
        i_rx = 1'b1;
        wait_cycles(30);
        chk("glitch_active_len", 32'(active_cnt), 32'd5);
        chk("glitch_active",     32'(o_active),   32'h0);
        chk("glitch_no_valid",   32'(valid_cnt),  32'd2);
        chk("glitch_no_ferr",    32'(ferr_cnt),   32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_cycles(20);
        chk("g3c_valid_cnt", 32'(valid_cnt), 32'd3);
        chk("g3c_byte",      32'(last_byte), 32'h3C);
        chk("g3c_perr",      32'(perr_cnt),  32'd1);

        // 0x55 with a low stop bit, then the line held low (break).
        send_frame(8'h55, 1'b0, 1'b0);
        active_cnt = 0;
        wait_cycles(30);
        chk("fe_ferr_cnt",   32'(ferr_cnt),   32'd1);
        chk("fe_no_valid",   32'(valid_cnt),  32'd3);
        chk("fe_no_restart", 32'(active_cnt), 32'd0);
        chk("fe_byte_kept",  32'(o_data_byte), 32'h3C);
        i_rx = 1'b1;
        wait_cycles(20);
        chk("fe_after_release_active", 32'(active_cnt), 32'd0);

        // Back-to-back frames with no idle gap.
        rx_log.delete();
        perr_log.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        wait_cycles(20);
        chk("b2b_valid_cnt", 32'(valid_cnt), 32'd6);
        chk("b2b_count",     32'(rx_log.size()), 32'd3);
        if (rx_log.size() == 3 && perr_log.size() == 3) begin
            chk("b2b_byte0", 32'(rx_log[0]), 32'h00);
            chk("b2b_byte1", 32'(rx_log[1]), 32'hFF);
            chk("b2b_byte2", 32'(rx_log[2]), 32'h80);
            chk("b2b_perr",  32'({perr_log[0], perr_log[1], perr_log[2]}), 32'h0);
        end
        chk("b2b_perr_cnt",  32'(perr_cnt), 32'd1);

        // Reset in the middle of data bit 4 aborts the frame.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bits({1'b1, 1'b0, 8'h96, 1'b0}, 5);
        i_rx = 1'b1;
        wait_cycles(3);
        chk("mid_frame_active", 32'(o_active), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_byte",   32'(o_data_byte), 32'h00);
        chk("rst_active", 32'(o_active),    32'h0);
        chk("rst_flags",  32'({o_data_valid, o_parity_err, o_frame_err}), 32'h0);
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(150);
        chk("rst_no_valid",  32'(valid_cnt), 32'(v0));
        chk("rst_no_ferr",   32'(ferr_cnt),  32'(f0));
        send_frame(8'h7E, 1'b0, 1'b1);
        wait_cycles(20);
        chk("post_rst_valid", 32'(valid_cnt), 32'(v0 + 1));
        chk("post_rst_byte",  32'(last_byte), 32'h7E);
        chk("post_rst_perr",  32'(last_perr), 32'h0);
        chk("no_stray_perr",  32'(stray_perr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
